// File: rtl/spectrum_bars.sv
// spectrum_bars: reduces each frame of N_BINS s.12 FFT magnitudes to N_BARS
// band maxima. The maxima are collected in a staging file and copied to the
// display file in a single COMMIT cycle. The display file is read through a
// registered port.
// Optional feature macro: PEAK_DECAY_EN. When it is defined, the display holds
// its peaks and each bar falls by DECAY per frame instead of being overwritten.
module spectrum_bars #(
    parameter int          N_BINS = 256,
    parameter int          N_BARS = 16,
    parameter logic [12:0] DECAY  = 13'd16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [12:0]               mag,
    input  logic                      mag_valid,
    input  logic                      mag_first,
    input  logic [$clog2(N_BARS)-1:0] rd_addr,
    output logic [12:0]               rd_data,
    output logic                      frame_done
);

    localparam int BPB     = N_BINS / N_BARS;
    localparam int BIN_W   = $clog2(N_BINS);
    localparam int BAR_W   = $clog2(N_BARS);
    localparam int LOG_BPB = $clog2(BPB);

    typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   commit;

    logic [BIN_W-1:0] bin_cnt;
    logic [BIN_W-1:0] cur_idx;
    logic [BIN_W-1:0] idx_low;
    logic [BAR_W-1:0] cur_band;
    logic             band_start;
    logic             band_last;
    logic [12:0]      mag_c;
    logic [12:0]      band_max;
    logic [12:0]      new_max;

    logic [12:0] stage [N_BARS];
    logic [12:0] disp  [N_BARS];

    // A negative s.12 magnitude carries no energy: clamp it to zero.
    function automatic logic [12:0] clamp0(input logic [12:0] m);
        return m[12] ? 13'd0 : m;
    endfunction

`ifdef PEAK_DECAY_EN
    // Lower a held peak by DECAY, saturating at zero.
    function automatic logic [12:0] decay_sat0(input logic [12:0] v);
        logic signed [13:0] diff;
        diff = $signed({1'b0, v}) - $signed({1'b0, DECAY});
        return (diff < 0) ? 13'd0 : diff[12:0];
    endfunction
`else
    logic unused_decay;
    assign unused_decay = ^DECAY;
`endif

    // A bin flagged mag_first is always bin 0. In ACCUM this restarts the frame.
    assign cur_idx    = mag_first ? '0 : bin_cnt;
    assign idx_low    = cur_idx & BIN_W'(BPB - 1);
    assign cur_band   = BAR_W'(cur_idx >> LOG_BPB);
    assign band_start = (idx_low == '0);
    assign band_last  = (idx_low == BIN_W'(BPB - 1));
    assign mag_c      = clamp0(mag);
    assign new_max    = (band_start || (mag_c > band_max)) ? mag_c : band_max;

    // Frame sequencing: next state, bin acceptance and the commit strobe.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (mag_valid && mag_first) begin
                    accept    = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (mag_valid) begin
                    accept = 1'b1;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept && (cur_idx == BIN_W'(N_BINS - 1))) begin
            state_nxt = COMMIT;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bin counting, running band maximum and write-back of finished bands to staging.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_cnt  <= '0;
            band_max <= '0;
            for (int b = 0; b < N_BARS; b++) begin
                stage[b] <= '0;
            end
        end else if (accept) begin
            bin_cnt  <= cur_idx + BIN_W'(1);
            band_max <= new_max;
            if (band_last) begin
                stage[cur_band] <= new_max;
            end
        end
    end

    // Copy the whole staging file into the display file in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < N_BARS; b++) begin
                disp[b] <= '0;
            end
        end else if (commit) begin
            for (int b = 0; b < N_BARS; b++) begin
`ifdef PEAK_DECAY_EN
                if (stage[b] > decay_sat0(disp[b])) begin
                    disp[b] <= stage[b];
                end else begin
                    disp[b] <= decay_sat0(disp[b]);
                end
`else
                disp[b] <= stage[b];
`endif
            end
        end
    end

    // Registered display read port and the frame-done pulse that follows the commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            rd_data    <= disp[rd_addr];
            frame_done <= commit;
        end
    end

endmodule

// File: doc/spectrum_bars.md
# spectrum_bars

Downstream consumer of the FFT magnitude stage: takes the per-bin s.12 magnitude stream produced after the FFT, reduces each frame of N_BINS bins to N_BARS bands by taking the band maximum, and holds the result in a display register file read by the bar-graph/display logic. Optionally applies peak-hold with linear decay so bars fall smoothly between frames.

## Interface
- N_BINS, 256: bins per frame. Power of 2, at least N_BARS.
- N_BARS, 16: output bands. Power of 2; N_BINS/N_BARS bins per band.
- DECAY, 13'd16: per-frame decay step in s.12 LSBs. Used only with decay compiled in.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mag  in  13  bin magnitude, s.12; negative values are clamped to 0
- mag_valid  in  1  mag valid this cycle; always accepted, no backpressure
- mag_first  in  1  qualifies bin 0 of a frame; meaningful only with mag_valid
- rd_addr  in  log2(N_BARS)  display read address
- rd_data  out  13  display value of band rd_addr, registered
- frame_done  out  1  one-cycle pulse after the display has been updated

## Operation
- States: IDLE, ACCUM, COMMIT.
- IDLE: wait for mag_valid && mag_first. That bin is bin 0: bin_cnt <= 1, band_max <= clamp(mag). Go to ACCUM.
- ACCUM: each mag_valid increments bin_cnt.
  - Band-start bin (bin_cnt % (N_BINS/N_BARS) == 0): band_max <= clamp(mag).
  - Otherwise: band_max <= max(band_max, clamp(mag)).
  - Last bin of a band: the final maximum, including the current bin, is written to stage[band].
  - After bin N_BINS-1 is accepted, go to COMMIT.
- mag_first with mag_valid while in ACCUM restarts the frame: that bin is bin 0, the partial stage is discarded, and disp is untouched.
- COMMIT, one cycle: for every band b, disp[b] <= stage[b]. Then go to IDLE. mag_valid is ignored in COMMIT, including mag_first; that frame is lost.
- Comparisons are unsigned on 13 bits after clamping. Clamp: bit 12 set -> 0.
- rd_data <= disp[rd_addr] every cycle, independent of state.
- Reset: state IDLE, bin_cnt 0, band_max 0, all stage and disp 0, rd_data 0, frame_done 0.

## Timing
- Cycle t: bin N_BINS-1 accepted.
- Cycle t+1: state COMMIT; disp is written at the end of t+1.
- Cycle t+2: frame_done = 1; state IDLE; a new mag_first is accepted.
- rd_data lags rd_addr by one cycle. rd_addr presented in t+1 returns the old value. rd_addr presented in t+2 returns the new value in t+3.
- Minimum frame period: N_BINS + 1 cycles, counting from bin 0 to the next acceptable bin 0.
- Gaps in mag_valid within a frame are allowed and of unbounded length.
- Reset asserted mid-frame: the partial frame is discarded, no frame_done is issued, and all outputs return to their reset values on the next edge.

## Configuration
- PEAK_DECAY_EN defined: in COMMIT, disp[b] <= max(stage[b], sat0(disp[b] - DECAY)), where sat0 saturates at 0.
- PEAK_DECAY_EN not defined: disp[b] <= stage[b]. The DECAY parameter is unused.

## Test plan
- Reset, then read all bands: rd_data = 0 for every rd_addr; frame_done is never asserted.
- N_BINS=256, N_BARS=16; frame with bin k = k*8. Band b reads (16b+15)*8; frame_done pulses exactly 2 cycles after bin 255.
- Frame containing mag = 13'h1F00 (negative) in band 0, all other bins 0: band 0 reads 0.
- Frame at full rate, then mag_first 1 cycle after the last bin (COMMIT) is ignored; mag_first 2 cycles after is accepted.
- Partial frame of 100 bins, then mag_first: restart; after the complete frame, disp reflects only the second frame.
- PEAK_DECAY_EN, DECAY=16: frame with band 3 = 1000, then an all-zero frame, gives band 3 = 984, then 968. With the macro undefined, band 3 = 0 after the zero frame.
